// File: rtl/result_log_pkg.sv
// Shared sizing defaults and the per-cycle action decode for result_log.
package result_log_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 8;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int PTR_W_DEF = ptr_w(DEPTH_DEF);
  localparam int CNT_W_DEF = cnt_w(DEPTH_DEF);

  // One winner per cycle: clear beats write beats browse step.
  typedef enum logic [2:0] {
    ACT_IDLE,
    ACT_CLR,
    ACT_WR,
    ACT_DROP,
    ACT_STEP
  } log_act_e;

endpackage

// File: rtl/rise_edge.sv
// Rising-edge detector for an already-debounced level; one pulse per low->high.
module rise_edge (
  input  logic clk,
  input  logic resetn,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!resetn) prev <= 1'b0;
    else         prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/result_log.sv
// Circular log of evaluator results with key-driven browsing of older entries.
// Optional build macro RESULT_LOG_DEDUP_EN drops a result equal to the newest entry.
module result_log
  import result_log_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int PTR_W = ptr_w(DEPTH),
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_data,
  input  logic             browse_next,
  input  logic             log_clr,
  output logic [WIDTH-1:0] sel_data,
  output logic [PTR_W-1:0] sel_offset,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_idx;
  logic             browse_pulse;
  logic             dup;
  logic             sel_last;
  log_act_e         act;

  rise_edge u_browse (
    .clk    (clk),
    .resetn (resetn),
    .level  (browse_next),
    .pulse  (browse_pulse)
  );

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

`ifdef RESULT_LOG_DEDUP_EN
  assign dup = !empty && (res_data == mem[wr_ptr - PTR_W'(1)]);
`else
  assign dup = 1'b0;
`endif

  // Newest entry sits just behind wr_ptr; power-of-two depth makes the wrap free.
  assign rd_idx   = wr_ptr - PTR_W'(1) - sel_offset;
  assign sel_last = ({1'b0, sel_offset} == count - CNT_W'(1));

  always_comb begin
    act = ACT_IDLE;
    if (log_clr)                    act = ACT_CLR;
    else if (res_valid)             act = dup ? ACT_DROP : ACT_WR;
    else if (browse_pulse && !empty) act = ACT_STEP;
  end

  always_ff @(posedge clk) begin
    if (resetn && act == ACT_WR) mem[wr_ptr] <= res_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      count      <= '0;
      sel_offset <= '0;
      sel_data   <= '0;
      overflow   <= 1'b0;
    end else begin
      // Selection is re-read every cycle, so it trails pointer/offset changes by one clock.
      sel_data <= empty ? '0 : mem[rd_idx];
      unique case (act)
        ACT_CLR: begin
          wr_ptr     <= '0;
          count      <= '0;
          sel_offset <= '0;
          sel_data   <= '0;
          overflow   <= 1'b0;
        end
        ACT_WR: begin
          wr_ptr     <= wr_ptr + PTR_W'(1);
          sel_offset <= '0;
          if (full) overflow <= 1'b1;
          else      count    <= count + CNT_W'(1);
        end
        ACT_STEP: sel_offset <= sel_last ? '0 : sel_offset + PTR_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_log.sv
// Directed + randomized bench for result_log against a queue-based log model.
module tb_result_log;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic             clk = 1'b0;
  logic             resetn, res_valid, browse_next, log_clr;
  logic [WIDTH-1:0] res_data;
  logic [WIDTH-1:0] sel_data;
  logic [PTR_W-1:0] sel_offset;
  logic [CNT_W-1:0] count;
  logic             empty, full, overflow;

  int n_checks = 0;
  int n_errors = 0;

  // Model: q[0] is the newest result, q[$] the oldest.
  logic [WIDTH-1:0] q[$];
  int               m_off;
  logic             m_ovf;
  logic [WIDTH-1:0] m_sel;
  logic             m_prev_b;

  result_log #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .browse_next (browse_next),
    .log_clr     (log_clr),
    .sel_data    (sel_data),
    .sel_offset  (sel_offset),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".sel_data"},   32'(sel_data),   32'(m_sel));
    check({tag, ".sel_offset"}, 32'(sel_offset), 32'(m_off));
    check({tag, ".count"},      32'(count),      32'(q.size()));
    check({tag, ".empty"},      32'(empty),      32'(q.size() == 0));
    check({tag, ".full"},       32'(full),       32'(q.size() == DEPTH));
    check({tag, ".overflow"},   32'(overflow),   32'(m_ovf));
  endtask

  // One clock: drive inputs, advance the model at the edge, compare #1 later.
  task automatic step(input logic rst, input logic v, input logic [WIDTH-1:0] d,
                      input logic b, input logic c);
    logic             edge_seen;
    logic [WIDTH-1:0] shown;
    resetn = ~rst; res_valid = v; res_data = d; browse_next = b; log_clr = c;
    @(posedge clk);
    edge_seen = b && !m_prev_b;
    shown     = (q.size() == 0) ? '0 : q[m_off];
    if (rst) begin
      q.delete(); m_off = 0; m_ovf = 1'b0; m_sel = '0; m_prev_b = 1'b0;
    end else begin
      m_prev_b = b;
      m_sel    = shown;
      if (c) begin
        q.delete(); m_off = 0; m_ovf = 1'b0; m_sel = '0;
      end else if (v) begin
        q.push_front(d);
        if (q.size() > DEPTH) begin
          void'(q.pop_back());
          m_ovf = 1'b1;
        end
        m_off = 0;
      end else if (edge_seen && q.size() > 0) begin
        m_off = (m_off == q.size() - 1) ? 0 : m_off + 1;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [WIDTH-1:0] d);
    step(1'b0, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic press();
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    q.delete(); m_off = 0; m_ovf = 1'b0; m_sel = '0; m_prev_b = 1'b0;
    resetn = 1'b0; res_valid = 1'b0; res_data = '0; browse_next = 1'b0; log_clr = 1'b0;

    // Reset state
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    check_all("reset");
    check("reset.empty_const", 32'(empty), 32'd1);

    // Single write, visible one clock later
    wr(8'h2A);
    check_all("w2a.n");
    idle();
    check_all("w2a.n1");
    check("w2a.sel_data", 32'(sel_data), 32'h2A);
    check("w2a.count", 32'(count), 32'd1);

    // Browse three entries with wrap back to newest
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    wr(8'h01); wr(8'h02); wr(8'h03); idle();
    press(); check_all("browse1"); check("browse1.sel_data", 32'(sel_data), 32'h02);
    press(); check_all("browse2"); check("browse2.sel_data", 32'(sel_data), 32'h01);
    press(); check_all("browse3"); check("browse3.sel_offset", 32'(sel_offset), 32'd0);
    // Held level gives a single step
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_all("held"); check("held.sel_offset", 32'(sel_offset), 32'd1);
    idle();

    // Overflow: nine writes into eight entries
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) wr(8'(8'h10 + i));
    idle();
    check_all("ovf");
    check("ovf.full", 32'(full), 32'd1);
    check("ovf.overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 7; i++) press();
    check_all("ovf.oldest");
    check("ovf.oldest_data", 32'(sel_data), 32'h11);

    // Write and browse edge in the same cycle: step discarded
    step(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_all("wr_vs_browse");
    check("wr_vs_browse.sel_data", 32'(sel_data), 32'h55);
    check("wr_vs_browse.sel_offset", 32'(sel_offset), 32'd0);
    idle();

    // Clear wins over a simultaneous write
    step(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
    idle();
    check_all("clr");
    check("clr.count", 32'(count), 32'd0);
    check("clr.overflow", 32'(overflow), 32'd0);

    // Duplicate writes are both stored in the default build
    wr(8'h07); wr(8'h07); idle();
    check("dup.count", 32'(count), 32'd2);

    // Empty log ignores browse edges
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    press();
    check_all("empty_browse");

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic rst_r, v_r, b_r, c_r;
      rst_r = ($urandom_range(0, 199) == 0);
      c_r   = ($urandom_range(0, 39) == 0);
      v_r   = ($urandom_range(0, 99) < 30);
      b_r   = ($urandom_range(0, 1) == 1);
      step(rst_r, v_r, 8'($urandom), b_r, c_r);
      check_all("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
